fifo_sync: RTL and testbench

//  Parametrised single-clock FWFT FIFO; next generation of the 2-entry crossing buffer, generalised in depth and width.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_mem.sv | 54 +++++
 rtl/fifo_sync.sv | 143 ++++++++++++++
 tb/tb_fifo_sync.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and types for the synchronous FWFT FIFO family.
package fifo_pkg;

  // Default geometry used when a parent does not override the parameters.
  localparam int DEF_WIDTH         = 8;
  localparam int DEF_DEPTH         = 8;
  localparam int DEF_AFULL_THRESH  = 6;
  localparam int DEF_AEMPTY_THRESH = 2;

  // Pointer width: index bits plus one wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Depth must be a power of two so the wrap bit gives free modulo arithmetic.
  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // Registered error strobes, kept together so they update as one unit.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/fifo_mem.sv
// 1-write / 1-read storage for fifo_sync with combinational read.
// Either a bank of individually enabled flops or a single inferred array.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int FLOPS_NOT_MEM = 0,
  localparam int AW           = ptr_width(DEPTH) - 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  if (FLOPS_NOT_MEM != 0) begin : g_flops
    // Per-entry outputs gathered so the read side is a plain mux.
    logic [WIDTH-1:0] entry_q [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic             sel;
      logic [WIDTH-1:0] data_reg;

      assign sel = i_we && (i_waddr == AW'(gi));

      // Each entry loads only when it is the write target; no reset, contents are don't-care until written.
      always_ff @(posedge i_clk) begin
        if (sel) begin
          data_reg <= i_wdata;
        end
      end

      assign entry_q[gi] = data_reg;
    end

    assign o_rdata = entry_q[i_raddr];

  end else begin : g_array
    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port into the inferred array; read below is asynchronous for first-word-fall-through.
    always_ff @(posedge i_clk) begin
      if (i_we) begin
        mem[i_waddr] <= i_wdata;
      end
    end

    assign o_rdata = mem[i_raddr];
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and error strobes.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
  parameter int FLOPS_NOT_MEM = 0,
  localparam int PTR_W        = ptr_width(DEPTH),
  localparam int CNT_W        = cnt_width(DEPTH),
  localparam int AW           = PTR_W - 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cg,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_wfull,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rempty,
  output logic [CNT_W-1:0] o_count,
  output logic             o_afull,
  output logic             o_aempty,
  output logic             o_overflow,
  output logic             o_underflow
);

  // Parameter sanity, caught at elaboration rather than in silicon.
  if (!is_pow2(DEPTH)) begin : g_chk_depth
    $error("fifo_sync: DEPTH must be a power of two and at least 2");
  end
  if (WIDTH < 1) begin : g_chk_width
    $error("fifo_sync: WIDTH must be at least 1");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_chk_afull
    $error("fifo_sync: AFULL_THRESH must lie in 1..DEPTH");
  end
  if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_chk_aempty
    $error("fifo_sync: AEMPTY_THRESH must lie in 0..DEPTH-1");
  end

  logic [PTR_W-1:0] wptr_reg, wptr_next;
  logic [PTR_W-1:0] rptr_reg, rptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  fifo_err_t        err_reg, err_next;

  logic full;
  logic empty;
  logic flush_en;
  logic do_push;
  logic do_pop;

  // Full/empty come only from registered pointers, so no input reaches a status flag combinationally.
  always_comb begin
    empty = (wptr_reg == rptr_reg);
    full  = (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]) && (wptr_reg[AW] != rptr_reg[AW]);
  end

  // Qualified requests: flush wins, a full FIFO refuses pushes, an empty one refuses pops (no bypass).
  always_comb begin
    flush_en = i_cg && i_flush;
    do_push  = i_cg && i_push && !full  && !i_flush;
    do_pop   = i_cg && i_pop  && !empty && !i_flush;
  end

  // Next pointer and occupancy; with i_cg low nothing qualifies and the state holds.
  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    if (flush_en) begin
      wptr_next  = '0;
      rptr_next  = '0;
      count_next = '0;
    end else begin
      if (do_push) begin
        wptr_next = wptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rptr_next = rptr_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Refused requests raise a strobe for exactly the following cycle; flush and a closed gate suppress them.
  always_comb begin
    err_next.overflow  = i_cg && i_push && full  && !i_flush;
    err_next.underflow = i_cg && i_pop  && empty && !i_flush;
  end

  // Pointer and count state; reset discards contents without touching storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
    end
  end

  // Error strobes reload every edge so they drop back after one cycle even when the gate closes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_reg <= '0;
    end else begin
      err_reg <= err_next;
    end
  end

  // Storage: written at the write index on an accepted push, head read asynchronously at the read index.
  fifo_mem #(
    .WIDTH         (WIDTH),
    .DEPTH         (DEPTH),
    .FLOPS_NOT_MEM (FLOPS_NOT_MEM)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (do_push),
    .i_waddr (wptr_reg[AW-1:0]),
    .i_wdata (i_wdata),
    .i_raddr (rptr_reg[AW-1:0]),
    .o_rdata (o_rdata)
  );

  // Status outputs decoded from registered state only.
  always_comb begin
    o_wfull     = full;
    o_rempty    = empty;
    o_count     = count_reg;
    o_afull     = (count_reg >= CNT_W'(AFULL_THRESH));
    o_aempty    = (count_reg <= CNT_W'(AEMPTY_THRESH));
    o_overflow  = err_reg.overflow;
    o_underflow = err_reg.underflow;
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Scoreboard bench for fifo_sync: an 8x8 array-backed instance and a 2x1 flop-backed instance.
module tb_fifo_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] cg, push, pop, flush;
  logic [7:0] wd_a;
  logic       wd_b;

  logic [7:0] rd_a;
  logic       rd_b;
  logic [3:0] cnt_a;
  logic [1:0] cnt_b;
  logic wfull_a, rempty_a, afull_a, aempty_a, ovf_a, udf_a;
  logic wfull_b, rempty_b, afull_b, aempty_b, ovf_b, udf_b;

  wire [7:0] rd  [2];
  wire [3:0] cnt [2];
  wire [5:0] flg [2];   // {wfull, rempty, afull, aempty, overflow, underflow}
  assign rd[0]  = rd_a;
  assign rd[1]  = {7'b0, rd_b};
  assign cnt[0] = cnt_a;
  assign cnt[1] = {2'b00, cnt_b};
  assign flg[0] = {wfull_a, rempty_a, afull_a, aempty_a, ovf_a, udf_a};
  assign flg[1] = {wfull_b, rempty_b, afull_b, aempty_b, ovf_b, udf_b};

  fifo_sync #(
    .WIDTH(8), .DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FLOPS_NOT_MEM(0)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg[0]), .i_flush(flush[0]),
    .i_push(push[0]), .i_wdata(wd_a), .o_wfull(wfull_a),
    .i_pop(pop[0]), .o_rdata(rd_a), .o_rempty(rempty_a), .o_count(cnt_a),
    .o_afull(afull_a), .o_aempty(aempty_a), .o_overflow(ovf_a), .o_underflow(udf_a)
  );

  fifo_sync #(
    .WIDTH(1), .DEPTH(2), .AFULL_THRESH(1), .AEMPTY_THRESH(0), .FLOPS_NOT_MEM(1)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg[1]), .i_flush(flush[1]),
    .i_push(push[1]), .i_wdata(wd_b), .o_wfull(wfull_b),
    .i_pop(pop[1]), .o_rdata(rd_b), .o_rempty(rempty_b), .o_count(cnt_b),
    .o_afull(afull_b), .o_aempty(aempty_b), .o_overflow(ovf_b), .o_underflow(udf_b)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_st(input int d, input string tag, input int c, input bit wf, input bit re,
                        input bit af, input bit ae, input bit ov, input bit ud);
    chk($sformatf("d%0d_%s_count", d, tag), 32'(cnt[d]), 32'(c));
    chk($sformatf("d%0d_%s_wfull", d, tag), 32'(flg[d][5]), 32'(wf));
    chk($sformatf("d%0d_%s_rempty", d, tag), 32'(flg[d][4]), 32'(re));
    chk($sformatf("d%0d_%s_afull", d, tag), 32'(flg[d][3]), 32'(af));
    chk($sformatf("d%0d_%s_aempty", d, tag), 32'(flg[d][2]), 32'(ae));
    chk($sformatf("d%0d_%s_overflow", d, tag), 32'(flg[d][1]), 32'(ov));
    chk($sformatf("d%0d_%s_underflow", d, tag), 32'(flg[d][0]), 32'(ud));
  endtask

  task automatic sb_push(input int d, input logic [7:0] v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back({7'b0, v[0]});
  endtask

  task automatic sb_clear(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  // One clock of stimulus; acc says whether the hand-worked expectation is that the push is accepted.
  task automatic op(input int d, input bit pu, input bit po, input logic [7:0] data,
                    input bit acc, input bit fl = 1'b0);
    push[d]  = pu;
    pop[d]   = po;
    flush[d] = fl;
    if (d == 0) wd_a = data;
    else        wd_b = data[0];
    if (fl && cg[d]) sb_clear(d);
    if (acc) sb_push(d, data);
    @(posedge clk);
    #1;
    push[d]  = 1'b0;
    pop[d]   = 1'b0;
    flush[d] = 1'b0;
  endtask

  // Monitor: whenever a DUT is about to accept a pop, its head must match the scoreboard front.
  always @(negedge clk) begin
    logic [7:0] e;
    bit         have;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (cg[d] && pop[d] && !flush[d] && !flg[d][4]) begin
          have = 1'b0;
          e    = 8'h00;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL d%0d_sb_underrun got pop with nothing expected at %0t", d, $time);
          end else begin
            chk($sformatf("d%0d_rdata", d), 32'(rd[d]), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    int cm;
    rst_n = 1'b0;
    cg    = 2'b11;
    push  = 2'b00;
    pop   = 2'b00;
    flush = 2'b00;
    wd_a  = 8'h00;
    wd_b  = 1'b0;
    #12;
    chk_st(0, "reset", 0, 0, 1, 0, 1, 0, 0);
    chk_st(1, "reset", 0, 0, 1, 0, 1, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill 8 words, then one refused push.
    for (int i = 1; i <= 8; i++) begin
      op(0, 1, 0, 8'(i), 1);
      chk_st(0, $sformatf("fill%0d", i), i, i == 8, 0, i >= 6, i <= 2, 0, 0);
    end
    op(0, 1, 0, 8'h09, 0);
    chk_st(0, "ovf", 8, 1, 0, 1, 0, 1, 0);
    op(0, 0, 0, 8'h00, 0);
    chk_st(0, "ovf_end", 8, 1, 0, 1, 0, 0, 0);

    // Drain all 8 in order, then one refused pop.
    for (int i = 1; i <= 8; i++) begin
      op(0, 0, 1, 8'h00, 0);
      chk_st(0, $sformatf("drain%0d", i), 8 - i, 0, i == 8, (8 - i) >= 6, (8 - i) <= 2, 0, 0);
    end
    op(0, 0, 1, 8'h00, 0);
    chk_st(0, "udf", 0, 0, 1, 0, 1, 0, 1);
    op(0, 0, 0, 8'h00, 0);
    chk_st(0, "udf_end", 0, 0, 1, 0, 1, 0, 0);

    // Steady state at 4 entries across pointer wrap.
    for (int i = 0; i < 4; i++) op(0, 1, 0, 8'h10 + 8'(i), 1);
    for (int i = 0; i < 20; i++) begin
      op(0, 1, 1, 8'h14 + 8'(i), 1);
      chk_st(0, "stream", 4, 0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) op(0, 0, 1, 8'h00, 0);
    chk_st(0, "stream_end", 0, 0, 1, 0, 1, 0, 0);

    // Full with push+pop: pop wins, push refused.
    for (int i = 0; i < 8; i++) op(0, 1, 0, 8'h40 + 8'(i), 1);
    chk_st(0, "full", 8, 1, 0, 1, 0, 0, 0);
    op(0, 1, 1, 8'h48, 0);
    chk_st(0, "full_pp", 7, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 7; i++) op(0, 0, 1, 8'h00, 0);
    // Empty with push+pop: push wins, pop refused.
    op(0, 1, 1, 8'h50, 1);
    chk_st(0, "empty_pp", 1, 0, 0, 0, 1, 0, 1);
    op(0, 0, 1, 8'h00, 0);
    chk_st(0, "empty_pp_end", 0, 0, 1, 0, 1, 0, 0);

    // Closed gate freezes everything.
    cg[0] = 1'b0;
    op(0, 1, 0, 8'h55, 0);
    chk_st(0, "gated", 0, 0, 1, 0, 1, 0, 0);
    cg[0] = 1'b1;

    // Flush at count 5 with a concurrent push.
    for (int i = 0; i < 5; i++) op(0, 1, 0, 8'h60 + 8'(i), 1);
    chk_st(0, "pre_flush", 5, 0, 0, 0, 0, 0, 0);
    op(0, 1, 0, 8'h65, 0, 1);
    chk_st(0, "flush", 0, 0, 1, 0, 1, 0, 0);
    op(0, 0, 1, 8'h00, 0, 1);
    chk_st(0, "flush_pop", 0, 0, 1, 0, 1, 0, 0);

    // Asynchronous reset in the middle of a burst.
    op(0, 1, 0, 8'h70, 1);
    op(0, 1, 0, 8'h71, 1);
    push[0] = 1'b1;
    wd_a    = 8'h72;
    #2 rst_n = 1'b0;
    #1;
    chk_st(0, "midrst", 0, 0, 1, 0, 1, 0, 0);
    push[0] = 1'b0;
    sb_clear(0);
    sb_clear(1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    op(0, 1, 0, 8'h7a, 1);
    chk_st(0, "post_rst", 1, 0, 0, 0, 1, 0, 0);
    op(0, 0, 1, 8'h00, 0);

    // Small flop-based instance, directed.
    op(1, 1, 0, 8'h01, 1);
    chk_st(1, "b_p1", 1, 0, 0, 1, 0, 0, 0);
    op(1, 1, 0, 8'h00, 1);
    chk_st(1, "b_full", 2, 1, 0, 1, 0, 0, 0);
    op(1, 1, 0, 8'h01, 0);
    chk_st(1, "b_ovf", 2, 1, 0, 1, 0, 1, 0);
    op(1, 1, 1, 8'h01, 0);
    chk_st(1, "b_full_pp", 1, 0, 0, 1, 0, 1, 0);
    op(1, 0, 1, 8'h00, 0);
    chk_st(1, "b_drain", 0, 0, 1, 0, 1, 0, 0);
    op(1, 0, 1, 8'h00, 0);
    chk_st(1, "b_udf", 0, 0, 1, 0, 1, 0, 1);
    op(1, 1, 1, 8'h01, 1);
    chk_st(1, "b_empty_pp", 1, 0, 0, 1, 0, 0, 1);
    op(1, 0, 1, 8'h00, 0);
    chk_st(1, "b_end", 0, 0, 1, 0, 1, 0, 0);

    // Random traffic against a count model, gate and flush toggled.
    cm = 0;
    for (int n = 0; n < 10000; n++) begin
      bit c, pu, po, fl, ap, ao, eo, eu;
      logic [7:0] dv;
      c  = ($urandom_range(0, 7) != 0);
      pu = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 99) == 0);
      dv = {7'b0, 1'($urandom_range(0, 1))};
      ap = c && pu && (cm != 2) && !fl;
      ao = c && po && (cm != 0) && !fl;
      eo = c && pu && (cm == 2) && !fl;
      eu = c && po && (cm == 0) && !fl;
      cg[1] = c;
      op(1, pu, po, dv, ap, fl);
      if (c && fl) cm = 0;
      else         cm = cm + int'(ap) - int'(ao);
      chk_st(1, "rnd", cm, cm == 2, cm == 0, cm >= 1, cm == 0, eo, eu);
    end
    cg[1] = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
